// File: rtl/ram_sp_pkg.sv
// Shared constants and types for the single-port synchronous RAM.
// Defaults size the generic datapath storage block.
package ram_sp_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int RAM_DEPTH_DEF  = 1024;

    typedef logic [DATA_WIDTH_DEF-1:0]         data_t;
    typedef logic [$clog2(RAM_DEPTH_DEF)-1:0] addr_t;

endpackage

// File: rtl/ram_sp_checker.sv
// Passive bus-protocol checker for ram_sp_sync_rw; simulation only.
// Built into the RAM only when RAM_SP_ASSERT_EN is defined.
module ram_sp_checker
    import ram_sp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RAM_DEPTH  = RAM_DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic [ADDR_WIDTH-1:0] address,
    input logic [DATA_WIDTH-1:0] data,
    input logic                  cs,
    input logic                  we,
    input logic                  oe,
    input logic [DATA_WIDTH-1:0] rd_q
);

    int unsigned n_rd;
    int unsigned n_wr;

    // Flag unknown or out-of-range bus values on every enabled edge.
    always @(posedge clk) begin
        if (rst_n && cs) begin
            if ($isunknown(address))
                $error("ram_sp: address unknown while selected");
            else if (32'(address) >= RAM_DEPTH)
                $error("ram_sp: address %0d out of range", address);
            if (we && $isunknown(data))
                $error("ram_sp: write data unknown");
        end
        if (!rst_n && rd_q != '0)
            $error("ram_sp: read register not cleared in reset");
    end

    // Tally accepted reads and writes for the end-of-run report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_rd <= 0;
            n_wr <= 0;
        end else if (cs && we) begin
            n_wr <= n_wr + 1;
        end else if (cs && oe) begin
            n_rd <= n_rd + 1;
        end
    end

    final $display("ram_sp: %0d reads, %0d writes", n_rd, n_wr);

endmodule

// File: rtl/ram_sp_sync_rw.sv
// Single-port RAM: synchronous write, registered read, shared tri-state bus.
// Define RAM_SP_ASSERT_EN to build in the ram_sp_checker protocol monitor.
module ram_sp_sync_rw
    import ram_sp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RAM_DEPTH  = RAM_DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  in_range;
    logic                  wr_en;
    logic                  rd_en;

    // A full power-of-two array can never be addressed out of range.
    generate
        if (RAM_DEPTH == (1 << ADDR_WIDTH)) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_partial
            localparam logic [ADDR_WIDTH-1:0] LAST =
                ADDR_WIDTH'(RAM_DEPTH - 1);
            assign in_range = (address <= LAST);
        end
    endgenerate

    assign wr_en = cs && we;
    assign rd_en = cs && !we && oe;

    // Store the bus word; writes during reset or past the end are dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en && in_range)
            mem[address] <= data;
    end

    // Registered read; an out-of-range read returns zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_q <= '0;
        else if (rd_en)
            rd_q <= in_range ? mem[address] : '0;
    end

    assign data = rd_en ? rd_q : 'z;

`ifdef RAM_SP_ASSERT_EN
    ram_sp_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_checker (
        .clk     (clk),
        .rst_n   (rst_n),
        .address (address),
        .data    (data),
        .cs      (cs),
        .we      (we),
        .oe      (oe),
        .rd_q    (rd_q)
    );
`endif

endmodule

// File: tb/tb_ram_sp_sync_rw.sv
// Directed bench for ram_sp_sync_rw with a word-level memory model.
// A weak pull-up on the bus makes an undriven bus read as all ones.
module tb_ram_sp_sync_rw;
    import ram_sp_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    addr_t      address;
    logic       cs;
    logic       we;
    logic       oe;
    logic       tb_drv;
    data_t      tb_dat;
    wire  [7:0] data;

    int n_run  = 0;
    int n_fail = 0;

    data_t mm [1024];
    bit    mk [1024];
    data_t sb [1024];
    data_t exp_rd = 8'h00;
    bit    exp_ok = 1'b1;

    localparam data_t PULL = 8'hFF;

    assign data = tb_drv ? tb_dat : 'z;

    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (data[i]);
    end

    ram_sp_sync_rw dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .address (address),
        .data    (data),
        .cs      (cs),
        .we      (we),
        .oe      (oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input data_t act, input data_t exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: what the bus must show after each edge.
    always @(posedge clk) begin
        if (rst_n && cs) begin
            if (we) begin
                mm[address] = data;
                mk[address] = 1'b1;
            end else if (oe) begin
                exp_rd = mm[address];
                exp_ok = mk[address];
            end
        end
    end

    always @(negedge rst_n) begin
        exp_rd = 8'h00;
        exp_ok = 1'b1;
    end

    // Per-cycle comparison of the bus against the model.
    initial forever begin
        @(posedge clk);
        #2;
        if (!tb_drv && exp_ok) begin
            if (cs && !we && oe)
                check("bus_read", data, exp_rd);
            else if (exp_rd != PULL)
                check("bus_idle_z", data, PULL);
        end
    end

    task automatic wr(input int a, input data_t d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; oe = 1'b0;
        address = addr_t'(a);
        tb_drv = 1'b1; tb_dat = d;
    endtask

    task automatic rd(input int a);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; oe = 1'b1;
        address = addr_t'(a);
        tb_drv = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        cs = 1'b0; we = 1'b0; oe = 1'b0;
        tb_drv = 1'b0;
    endtask

    task automatic rd_chk(input string name, input int a, input data_t e);
        rd(a);
        @(posedge clk);
        #2;
        check(name, data, e);
    endtask

    task automatic fill(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            sb[a] = data_t'($urandom(a) % 255);
            wr(a, sb[a]);
        end
    endtask

    task automatic readback(input int lo, input int hi);
        for (int a = lo; a <= hi; a++)
            rd_chk("fill_rd", a, sb[a]);
    endtask

    initial begin
        rst_n = 1'b1;
        cs = 1'b1; we = 1'b0; oe = 1'b1;
        address = '0;
        tb_drv = 1'b0; tb_dat = '0;
        #1 rst_n = 1'b0;

        // Reset: enabled read drives zero, deselect floats
        repeat (2) @(posedge clk);
        #2 check("rst_rd_zero", data, 8'h00);
        #1 cs = 1'b0;
        #1 check("rst_cs0_z", data, PULL);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read, including the top word
        wr(0, 8'hA5);
        wr(1, 8'h3C);
        wr(1023, 8'hFF);
        rd_chk("rd_0", 0, 8'hA5);
        rd_chk("rd_1", 1, 8'h3C);
        rd_chk("rd_1023", 1023, 8'hFF);

        // Asynchronous reset in the middle of a read stream
        wr(5, 8'h5A);
        rd_chk("rd_5", 5, 8'h5A);
        rd(5);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("rst_mid_async", data, 8'h00);
        rst_n = 1'b1;
        rd_chk("rd_5_after_rst", 5, 8'h5A);

        // Bus control
        @(negedge clk);
        cs = 1'b1; we = 1'b1; oe = 1'b1;
        address = 20; tb_drv = 1'b1; tb_dat = 8'h77;
        @(negedge clk);
        address = 21; tb_drv = 1'b0;
        #1 check("wr_oe_no_drive", data, PULL);
        @(negedge clk);
        cs = 1'b0; we = 1'b0; oe = 1'b1;
        #1 check("cs0_oe1_z", data, PULL);
        rd_chk("rd_20", 20, 8'h77);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; oe = 1'b0;
        address = 0;
        #1 check("oe0_z", data, PULL);
        @(posedge clk);
        #3 oe = 1'b1;
        #1 check("oe_rise_hold", data, 8'h77);
        idle();

        // Block fill and readback
        fill(0, 153);
        fill(409, 613);
        fill(870, 1023);
        readback(0, 153);
        readback(409, 613);
        readback(870, 1023);

        // Same-address overwrite on consecutive cycles
        wr(7, 8'h11);
        wr(7, 8'h22);
        rd_chk("overwrite_7", 7, 8'h22);

        idle();
        repeat (3) @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
